trng_pool_arbiter: RTL and testbench
====================================

TRNG_POOL_ARBITER -- requirements
Module: trng_pool_arbiter

Interface
REQ-001 SHALL have port: clk  in  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: req0_valid  in  1 / req0_ready  out  1  requester 0 byte request handshake.
REQ-004 SHALL have ports: req1_valid  in  1 / req1_ready  out  1  requester 1 byte request handshake.
REQ-005 SHALL have ports: rsp0_valid  out  1 / rsp0_data  out  8  requester 0 response (no backpressure).
REQ-006 SHALL have ports: rsp1_valid  out  1 / rsp1_data  out  8  requester 1 response (no backpressure).
REQ-007 SHALL have ports: bram_en  out  1, bram_we  out  1, bram_addr  out  3, bram_din  out  8, bram_dout  in  8  to the 8x8 entropy pool BRAM (1-cycle read latency).
REQ-008 SHALL have ports (TRNG_POOL_RESEED_EN only): seed_valid  in  1, seed_ready  out  1, seed_data  in  8.

Function
REQ-009 SHALL hold a private 3-bit read pointer per requester; grant reads the pool at that pointer, then increments it (7 wraps to 0).
REQ-010 Grant of requester X in cycle N: reqX_valid && reqX_ready; bram_en=1, bram_we=0, bram_addr=ptrX combinationally in cycle N.
REQ-011 rspX_data SHALL register bram_dout at end of cycle N+1; rspX_valid high for exactly cycle N+2; one grant per cycle, fully pipelined.
REQ-012 At most one requester ready per cycle; reqX_ready may depend on reqX_valid.
REQ-013 Arbitration SHALL be 2-way round-robin: both valid -> grant the one not granted last; one valid -> grant it every cycle.
REQ-014 bram_en SHALL be 0 in cycles with no grant and no seed write.
REQ-015 FSM states RUN and RESEED; reads granted only in RUN.

Reset
REQ-016 Reset SHALL set: FSM=RUN, both pointers=0, round-robin favours req0, in-flight pipeline cleared.
REQ-017 Reset output values: all ready/valid=0, rspX_data=0, bram_en=0, bram_we=0, bram_addr=0, bram_din=0.
REQ-018 Reset mid-read SHALL suppress the pending rspX_valid; reset mid-reseed SHALL abandon remaining writes.

Configuration
REQ-019 Macro TRNG_POOL_RESEED_EN SHALL compile in the reseed path (REQ-020..REQ-024) and REQ-008 ports.
REQ-020 With macro: per-requester read count (0..8) since last reseed; count 8 -> reqX_ready=0 (no entropy reuse).
REQ-021 With macro: seed_valid in RUN SHALL block all grants that cycle and enter RESEED next cycle.
REQ-022 With macro: in RESEED, seed_ready=1; each seed handshake writes seed_data to addresses 0..7 in order (bram_en=1, bram_we=1).
REQ-023 With macro: after the 8th write, return to RUN; pointers and read counts cleared to 0.
REQ-024 With macro: reads in flight at RESEED entry SHALL still return (data as read before the write).
REQ-025 Without macro: no seed ports, bram_we and bram_din tied 0, no exhaustion; pointers wrap indefinitely.

Structure
REQ-026 Package trng_pool_pkg SHALL hold POOL_DEPTH=8, ADDR_W=3, DATA_W=8 and the RUN/RESEED state enum.
REQ-027 Round-robin selection SHALL be sub-module trng_rr_arb2 (2 valids, last-grant state, one-hot grant).

Verification
REQ-028 Pool preloaded 0x10..0x17; req0_valid held 10 cycles alone -> rsp0_data 0x10..0x17,0x10,0x11, each 2 cycles after its grant.
REQ-029 Both valid continuously from reset -> grants alternate req0,req1,...; each receives 0x10,0x11,0x12... independently.
REQ-030 Reset asserted cycle after grant -> no rspX_valid; next read after reset returns pool[0].
REQ-031 (macro) req0 makes 8 reads -> req0_ready stays 0 while req1 still served; after reseed 0xA0..0xA7, req0 reads 0xA0.
REQ-032 (macro) seed_valid and req1_valid same RUN cycle -> no grant, RESEED next cycle, 8 writes addr 0..7, then RUN.
REQ-033 (macro) seed_valid gaps mid-RESEED -> FSM stays RESEED, writes resume at the next address, no reads granted.

Source files
------------

// File: rtl/trng_pool_pkg.sv
// Shared sizing and FSM state type for the TRNG entropy pool arbiter.
// Reseed support in the users of this package is enabled by TRNG_POOL_RESEED_EN.
package trng_pool_pkg;

    localparam int POOL_DEPTH = 8;
    localparam int ADDR_W     = 3;
    localparam int DATA_W     = 8;
    localparam int CNT_W      = $clog2(POOL_DEPTH + 1);

    typedef enum logic {
        RUN    = 1'b0,
        RESEED = 1'b1
    } state_t;

endpackage

// File: rtl/trng_rr_arb2.sv
// Two-way round-robin arbiter with one-hot grant; favours requester 0 after reset.
module trng_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant
);

    // High when requester 1 held the most recent grant.
    logic r_last_req1;

    always_comb begin
        o_grant = i_valid;
        if (i_valid == 2'b11) begin
            o_grant = r_last_req1 ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_req1 <= 1'b1;
        end else if (|o_grant) begin
            r_last_req1 <= o_grant[1];
        end
    end

endmodule

// File: rtl/trng_pool_arbiter.sv
// Shares an 8x8 entropy pool BRAM between two byte requesters, each with its own read pointer.
// Define TRNG_POOL_RESEED_EN to add the seed port, per-requester read limits and the reseed path.
module trng_pool_arbiter
    import trng_pool_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req1_valid,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
`ifdef TRNG_POOL_RESEED_EN
    input  logic              seed_valid,
    output logic              seed_ready,
    input  logic [DATA_W-1:0] seed_data,
`endif
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout
);

    state_t            r_state;
    state_t            w_state_next;
    logic              w_run_ok;
    logic [1:0]        w_valid;
    logic [1:0]        w_elig;
    logic [1:0]        w_grant;
    logic [1:0]        w_rsp_valid;
    logic [ADDR_W-1:0] w_ptr      [2];
    logic [DATA_W-1:0] w_rsp_data [2];

`ifdef TRNG_POOL_RESEED_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(POOL_DEPTH - 1);
    logic [ADDR_W-1:0] r_seed_idx;
    logic              w_seed_wr;
    logic              w_reseed_done;

    assign w_reseed_done = w_seed_wr && (r_seed_idx == LAST_ADDR);
`endif

    assign w_valid = {req1_valid, req0_valid};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_run_ok     = 1'b0;
`ifdef TRNG_POOL_RESEED_EN
        w_seed_wr    = 1'b0;
        seed_ready   = 1'b0;
`endif
        case (r_state)
            RUN: begin
                w_run_ok = !reset;
`ifdef TRNG_POOL_RESEED_EN
                // A pending seed freezes reads so the pool is never read mid-refill.
                if (seed_valid) begin
                    w_run_ok     = 1'b0;
                    w_state_next = RESEED;
                end
`endif
            end
            RESEED: begin
`ifdef TRNG_POOL_RESEED_EN
                seed_ready = !reset;
                w_seed_wr  = seed_valid && !reset;
                if (w_seed_wr && (r_seed_idx == LAST_ADDR)) begin
                    w_state_next = RUN;
                end
`else
                w_state_next = RUN;
`endif
            end
            default: w_state_next = RUN;
        endcase
    end

`ifdef TRNG_POOL_RESEED_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seed_idx <= '0;
        end else if (w_seed_wr) begin
            r_seed_idx <= r_seed_idx + 1'b1;
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            logic [ADDR_W-1:0] r_ptr;
            logic              r_rd;
            logic              r_rsp_valid;
            logic [DATA_W-1:0] r_rsp_data;
`ifdef TRNG_POOL_RESEED_EN
            logic [CNT_W-1:0]  r_cnt;

            // An exhausted requester waits for fresh seed rather than reuse entropy.
            assign w_elig[gi] = w_valid[gi] && w_run_ok && (r_cnt != CNT_W'(POOL_DEPTH));
`else
            assign w_elig[gi] = w_valid[gi] && w_run_ok;
`endif

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_ptr       <= '0;
                    r_rd        <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_rsp_data  <= '0;
`ifdef TRNG_POOL_RESEED_EN
                    r_cnt       <= '0;
`endif
                end else begin
                    r_rd        <= w_grant[gi];
                    r_rsp_valid <= r_rd;
                    if (r_rd) begin
                        r_rsp_data <= bram_dout;
                    end
`ifdef TRNG_POOL_RESEED_EN
                    if (w_reseed_done) begin
                        r_ptr <= '0;
                        r_cnt <= '0;
                    end else if (w_grant[gi]) begin
                        r_ptr <= r_ptr + 1'b1;
                        r_cnt <= r_cnt + 1'b1;
                    end
`else
                    if (w_grant[gi]) begin
                        r_ptr <= r_ptr + 1'b1;
                    end
`endif
                end
            end

            assign w_ptr[gi]       = r_ptr;
            assign w_rsp_valid[gi] = r_rsp_valid;
            assign w_rsp_data[gi]  = r_rsp_data;
        end
    endgenerate

    trng_rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_elig),
        .o_grant (w_grant)
    );

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];
    assign rsp0_valid = w_rsp_valid[0];
    assign rsp1_valid = w_rsp_valid[1];
    assign rsp0_data  = w_rsp_data[0];
    assign rsp1_data  = w_rsp_data[1];

    always_comb begin
        bram_en   = 1'b0;
        bram_we   = 1'b0;
        bram_addr = '0;
        bram_din  = '0;
        if (w_grant[0]) begin
            bram_en   = 1'b1;
            bram_addr = w_ptr[0];
        end else if (w_grant[1]) begin
            bram_en   = 1'b1;
            bram_addr = w_ptr[1];
        end
`ifdef TRNG_POOL_RESEED_EN
        if (w_seed_wr) begin
            bram_en   = 1'b1;
            bram_we   = 1'b1;
            bram_addr = r_seed_idx;
            bram_din  = seed_data;
        end
`endif
    end

endmodule

// File: tb/tb_trng_pool_arbiter.sv
// Directed bench for trng_pool_arbiter with a behavioural 8x8 pool BRAM preloaded 0x10..0x17.
// Reseed scenarios are exercised when TRNG_POOL_RESEED_EN is defined.
module tb_trng_pool_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic       rsp0_valid, rsp1_valid;
    logic [7:0] rsp0_data, rsp1_data;
    logic       bram_en, bram_we;
    logic [2:0] bram_addr;
    logic [7:0] bram_din;
    logic [7:0] bram_dout;
    logic       preload;
    logic [7:0] mem [8];
`ifdef TRNG_POOL_RESEED_EN
    logic       seed_valid, seed_ready;
    logic [7:0] seed_data;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    trng_pool_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
`ifdef TRNG_POOL_RESEED_EN
        .seed_valid (seed_valid),
        .seed_ready (seed_ready),
        .seed_data  (seed_data),
`endif
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .bram_dout  (bram_dout)
    );

    // Read-first pool with one cycle of read latency.
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 8; k++) mem[k] <= 8'h10 + 8'(k);
        end else if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_din;
            else         bram_dout <= mem[bram_addr];
        end
    end

    always @(negedge clk) begin
        if (rsp0_valid) $display("rsp0 data=0x%02h @%0t", rsp0_data, $time);
        if (rsp1_valid) $display("rsp1 data=0x%02h @%0t", rsp1_data, $time);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        preload    = 1'b1;
`ifdef TRNG_POOL_RESEED_EN
        seed_valid = 1'b0;
        seed_data  = 8'h00;
`endif
        step();
        preload = 1'b0;
        step();
        #1;
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_rsp0_data",  rsp0_data,  0);
        check("rst_rsp1_data",  rsp1_data,  0);
        check("rst_bram_en",    bram_en,    0);
        check("rst_bram_we",    bram_we,    0);
        check("rst_bram_addr",  bram_addr,  0);
        check("rst_bram_din",   bram_din,   0);
        reset      = 1'b0;
        req0_valid = 1'b0;
        step();

        // req0 alone for 10 cycles: pointer wraps, each byte lands two cycles after its grant.
        for (int i = 0; i < 12; i++) begin
            req0_valid = (i < 10);
            #1;
            if (i < 10) begin
                check("solo_ready", req0_ready, 1);
                check("solo_addr",  bram_addr,  i % 8);
            end else begin
                check("solo_idle_en", bram_en, 0);
            end
            check("solo_rsp_valid", rsp0_valid, (i >= 2) ? 1 : 0);
            if (i >= 2) check("solo_rsp_data", rsp0_data, 32'h10 + (i - 2) % 8);
            check("solo_rsp1_quiet", rsp1_valid, 0);
            step();
        end
        req0_valid = 1'b0;

        // Both valid from reset: strict alternation, independent pointers.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            req0_valid = (i < 8);
            req1_valid = (i < 8);
            #1;
            if (i < 8) begin
                check("rr_req0_ready", req0_ready, (i % 2 == 0) ? 1 : 0);
                check("rr_req1_ready", req1_ready, (i % 2 == 1) ? 1 : 0);
                check("rr_addr",       bram_addr,  i / 2);
            end
            if (i >= 2) begin
                check("rr_rsp0_valid", rsp0_valid, ((i - 2) % 2 == 0) ? 1 : 0);
                check("rr_rsp1_valid", rsp1_valid, ((i - 2) % 2 == 1) ? 1 : 0);
                if ((i - 2) % 2 == 0) check("rr_rsp0_data", rsp0_data, 32'h10 + (i - 2) / 2);
                else                  check("rr_rsp1_data", rsp1_data, 32'h10 + (i - 2) / 2);
            end else begin
                check("rr_rsp_quiet", {rsp1_valid, rsp0_valid}, 0);
            end
            step();
        end

        // Reset right after a grant drops its response and rewinds the pointer.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            req0_valid = (i < 3) || (i == 5);
            reset      = (i == 3);
            #1;
            if (i == 2) check("mid_rsp_before", rsp0_data, 32'h10);
            if (i == 4 || i == 5) check("mid_rsp_suppressed", rsp0_valid, 0);
            if (i == 5) begin
                check("mid_after_ready", req0_ready, 1);
                check("mid_after_addr",  bram_addr,  0);
            end
            if (i == 7) begin
                check("mid_after_valid", rsp0_valid, 1);
                check("mid_after_data",  rsp0_data,  32'h10);
            end
            step();
        end
        reset      = 1'b0;
        req0_valid = 1'b0;

`ifdef TRNG_POOL_RESEED_EN
        do_reset();
        for (int i = 0; i < 8; i++) begin
            req0_valid = 1'b1;
            #1;
            check("exh_req0_ready", req0_ready, 1);
            check("exh_req0_addr",  bram_addr,  i);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            #1;
            check("exh_req0_blocked", req0_ready, 0);
            check("exh_req1_served",  req1_ready, 1);
            check("exh_req1_addr",    bram_addr,  i);
            step();
        end
        // Seed arrives together with a read request: nothing granted this cycle.
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        seed_valid = 1'b1;
        seed_data  = 8'hA0;
        #1;
        check("seed_run_ready", seed_ready, 0);
        check("seed_run_grant", req1_ready, 0);
        check("seed_run_en",    bram_en,    0);
        step();
        begin
            int k = 0;
            for (int c = 0; c < 9; c++) begin
                seed_valid = (c != 3);
                seed_data  = 8'hA0 + 8'(k);
                #1;
                if (c == 0) begin
                    check("inflight_valid", rsp1_valid, 1);
                    check("inflight_data",  rsp1_data,  32'h11);
                end
                check("rs_seed_ready", seed_ready, 1);
                check("rs_no_grant",   req1_ready, 0);
                check("rs_en",         bram_en,    seed_valid);
                if (seed_valid) begin
                    check("rs_we",   bram_we,   1);
                    check("rs_addr", bram_addr, k);
                    check("rs_din",  bram_din,  32'hA0 + k);
                    k++;
                end
                step();
            end
        end
        seed_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req0_valid = (i < 2);
            req1_valid = (i < 2);
            #1;
            if (i == 0) begin
                check("post_req0_ready", req0_ready, 1);
                check("post_req0_addr",  bram_addr,  0);
            end
            if (i == 1) begin
                check("post_req1_ready", req1_ready, 1);
                check("post_req1_addr",  bram_addr,  0);
            end
            if (i == 2) check("post_rsp0_data", rsp0_data, 32'hA0);
            if (i == 3) check("post_rsp1_data", rsp1_data, 32'hA0);
            step();
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
